// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default widths, bus packet type and the index-width helper.
package cdb_arbiter_pkg;

  localparam int CDB_XLEN  = 32;
  localparam int ROB_TAG_W = 3;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                valid;
    rob_tag_t            tag;
    logic [CDB_XLEN-1:0] value;
  } cdb_packet_t;

  // Width of a binary index into n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_priority_sel.sv
// Round-robin priority select: first set request at or after ptr, wrapping mod N.
module cdb_arbiter_rr_priority_sel
  import cdb_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                        = 1'b1;
        gnt[(int'(ptr) + k) % N]   = 1'b1;
        idx                        = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one completing FU per cycle round-robin and registers its broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_FU  = 4,
  parameter int TAG_W = ROB_TAG_W,
  parameter int XLEN  = CDB_XLEN,
  parameter int IW    = idx_w(N_FU)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_FU-1:0]            fu_valid,
  input  logic [N_FU-1:0][TAG_W-1:0] fu_tag,
  input  logic [N_FU-1:0][XLEN-1:0]  fu_value,
  input  logic                       cdb_stall,
  input  logic                       squash,
  output logic [N_FU-1:0]            fu_grant,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [XLEN-1:0]            cdb_value,
  output logic [IW-1:0]              cdb_fu_idx
);

  logic [N_FU-1:0]  sel_gnt;
  logic [IW-1:0]    sel_idx;
  logic             sel_any;
  logic             grant_any;

  logic [IW-1:0]    rr_ptr_q,     rr_ptr_d;
  logic             cdb_valid_q,  cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q,    cdb_tag_d;
  logic [XLEN-1:0]  cdb_value_q,  cdb_value_d;
  logic [IW-1:0]    cdb_fu_idx_q, cdb_fu_idx_d;

  cdb_arbiter_rr_priority_sel #(.N(N_FU), .IW(IW)) u_sel (
    .req (fu_valid),
    .ptr (rr_ptr_q),
    .gnt (sel_gnt),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Reset gates the grant too, so an FU never sees a handshake that the flops will drop.
  always_comb begin
    grant_any    = sel_any & ~(cdb_stall | squash | reset);
    fu_grant     = grant_any ? sel_gnt : '0;
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = grant_any;
    cdb_tag_d    = cdb_tag_q;
    cdb_value_d  = cdb_value_q;
    cdb_fu_idx_d = cdb_fu_idx_q;
    if (grant_any) begin
      rr_ptr_d     = (sel_idx == IW'(N_FU - 1)) ? '0 : sel_idx + 1'b1;
      cdb_tag_d    = fu_tag[sel_idx];
      cdb_value_d  = fu_value[sel_idx];
      cdb_fu_idx_d = sel_idx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
      cdb_fu_idx_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_value_q  <= cdb_value_d;
      cdb_fu_idx_q <= cdb_fu_idx_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_fu_idx = cdb_fu_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: round-robin order, wrap, stall, squash and async reset.
module tb_cdb_arbiter;

  localparam int N_FU  = 4;
  localparam int TAG_W = 3;
  localparam int XLEN  = 32;
  localparam int IW    = 2;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [N_FU-1:0]            fu_valid;
  logic [N_FU-1:0][TAG_W-1:0] fu_tag;
  logic [N_FU-1:0][XLEN-1:0]  fu_value;
  logic                       cdb_stall;
  logic                       squash;
  logic [N_FU-1:0]            fu_grant;
  logic                       cdb_valid;
  logic [TAG_W-1:0]           cdb_tag;
  logic [XLEN-1:0]            cdb_value;
  logic [IW-1:0]              cdb_fu_idx;

  int n_chk  = 0;
  int n_fail = 0;

  cdb_arbiter #(.N_FU(N_FU), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock      (clock),
    .reset      (reset),
    .fu_valid   (fu_valid),
    .fu_tag     (fu_tag),
    .fu_value   (fu_value),
    .cdb_stall  (cdb_stall),
    .squash     (squash),
    .fu_grant   (fu_grant),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .cdb_fu_idx (cdb_fu_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Drive one cycle's request at the negedge, check the combinational grant, advance past the edge.
  task automatic cyc(input logic [3:0] v, input logic st, input logic sq,
                     input logic [3:0] exp_g, input string name);
    @(negedge clock);
    fu_valid  = v;
    cdb_stall = st;
    squash    = sq;
    #1 chk({name, " grant"}, 64'(fu_grant), 64'(exp_g));
    @(posedge clock);
    #1;
  endtask

  task automatic bus(input logic [2:0] tag, input logic [31:0] val, input logic [1:0] idx,
                     input logic [1:0] ptr, input string name);
    chk({name, " valid"}, 64'(cdb_valid), 64'(1'b1));
    chk({name, " tag"},   64'(cdb_tag),   64'(tag));
    chk({name, " value"}, 64'(cdb_value), 64'(val));
    chk({name, " idx"},   64'(cdb_fu_idx), 64'(idx));
    chk({name, " ptr"},   64'(dut.rr_ptr_q), 64'(ptr));
  endtask

  task automatic idle(input logic [1:0] ptr, input string name);
    chk({name, " valid"}, 64'(cdb_valid), 64'(1'b0));
    chk({name, " ptr"},   64'(dut.rr_ptr_q), 64'(ptr));
  endtask

  initial begin
    reset     = 1'b1;
    fu_valid  = 4'b1111;
    fu_tag    = '0;
    fu_value  = '0;
    cdb_stall = 1'b0;
    squash    = 1'b0;

    // Reset state, with requests present to show grant is held off.
    #3;
    chk("rst grant", 64'(fu_grant),   64'h0);
    chk("rst valid", 64'(cdb_valid),  64'h0);
    chk("rst tag",   64'(cdb_tag),    64'h0);
    chk("rst value", 64'(cdb_value),  64'h0);
    chk("rst idx",   64'(cdb_fu_idx), 64'h0);
    chk("rst ptr",   64'(dut.rr_ptr_q), 64'h0);
    fu_valid = 4'b0000;
    @(negedge clock);
    reset = 1'b0;

    // Single request from FU2.
    fu_tag[2]   = 3'd5;
    fu_value[2] = 32'hDEADBEEF;
    cyc(4'b0100, 1'b0, 1'b0, 4'b0100, "single");
    bus(3'd5, 32'hDEADBEEF, 2'd2, 2'd3, "single");
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, "single drop");
    idle(2'd3, "single drop");

    // All four valid from a fresh reset: grants 0,1,2,3,0.
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rst2 ptr", 64'(dut.rr_ptr_q), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < N_FU; i++) begin
      fu_tag[i]   = TAG_W'(i + 4);
      fu_value[i] = 32'hA000_0000 + 32'(i);
    end
    cyc(4'b1111, 1'b0, 1'b0, 4'b0001, "rr0");
    bus(3'd4, 32'hA000_0000, 2'd0, 2'd1, "rr0");
    cyc(4'b1111, 1'b0, 1'b0, 4'b0010, "rr1");
    bus(3'd5, 32'hA000_0001, 2'd1, 2'd2, "rr1");
    cyc(4'b1111, 1'b0, 1'b0, 4'b0100, "rr2");
    bus(3'd6, 32'hA000_0002, 2'd2, 2'd3, "rr2");
    cyc(4'b1111, 1'b0, 1'b0, 4'b1000, "rr3");
    bus(3'd7, 32'hA000_0003, 2'd3, 2'd0, "rr3");
    cyc(4'b1111, 1'b0, 1'b0, 4'b0001, "rr4");
    bus(3'd4, 32'hA000_0000, 2'd0, 2'd1, "rr4");

    // Move pointer to 3, then FU3 and FU0 alternate.
    cyc(4'b0100, 1'b0, 1'b0, 4'b0100, "fair setup");
    bus(3'd6, 32'hA000_0002, 2'd2, 2'd3, "fair setup");
    cyc(4'b1001, 1'b0, 1'b0, 4'b1000, "fair a");
    bus(3'd7, 32'hA000_0003, 2'd3, 2'd0, "fair a");
    cyc(4'b1001, 1'b0, 1'b0, 4'b0001, "fair b");
    bus(3'd4, 32'hA000_0000, 2'd0, 2'd1, "fair b");
    cyc(4'b1001, 1'b0, 1'b0, 4'b1000, "fair c");
    bus(3'd7, 32'hA000_0003, 2'd3, 2'd0, "fair c");

    // Two stalled cycles with FU1 waiting.
    cyc(4'b0010, 1'b1, 1'b0, 4'b0000, "stall1");
    idle(2'd0, "stall1");
    cyc(4'b0010, 1'b1, 1'b0, 4'b0000, "stall2");
    idle(2'd0, "stall2");
    cyc(4'b0010, 1'b0, 1'b0, 4'b0010, "post stall");
    bus(3'd5, 32'hA000_0001, 2'd1, 2'd2, "post stall");

    // Squash: the broadcast already on the bus stays visible, next cycle is empty.
    cyc(4'b1111, 1'b0, 1'b0, 4'b0100, "pre squash");
    bus(3'd6, 32'hA000_0002, 2'd2, 2'd3, "pre squash");
    @(negedge clock);
    squash = 1'b1;
    #1;
    chk("squash grant",  64'(fu_grant),   64'h0);
    chk("squash inflt v", 64'(cdb_valid), 64'h1);
    chk("squash inflt i", 64'(cdb_fu_idx), 64'h2);
    @(posedge clock);
    #1 idle(2'd3, "squash");
    cyc(4'b1111, 1'b1, 1'b1, 4'b0000, "stall+squash");
    idle(2'd3, "stall+squash");
    cyc(4'b1111, 1'b0, 1'b0, 4'b1000, "post squash");
    bus(3'd7, 32'hA000_0003, 2'd3, 2'd0, "post squash");
    cyc(4'b1111, 1'b0, 1'b0, 4'b0001, "pre reset");
    bus(3'd4, 32'hA000_0000, 2'd0, 2'd1, "pre reset");

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    chk("async grant", 64'(fu_grant),   64'h0);
    chk("async valid", 64'(cdb_valid),  64'h0);
    chk("async tag",   64'(cdb_tag),    64'h0);
    chk("async value", 64'(cdb_value),  64'h0);
    chk("async idx",   64'(cdb_fu_idx), 64'h0);
    chk("async ptr",   64'(dut.rr_ptr_q), 64'h0);
    fu_valid = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    cyc(4'b0110, 1'b0, 1'b0, 4'b0010, "after reset");
    bus(3'd5, 32'hA000_0001, 2'd1, 2'd2, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
